// File: rtl/dc_fu_dma_burst_manager.sv
// AXI4 read-channel burst manager for the fetch-unit DMA: credit-gated AR issue,
// R beat accounting, burst-length checking and sticky worst-RRESP capture.
module dc_fu_dma_burst_manager #(
    parameter int TRANS_COUNT_WIDTH = 12,
    parameter int BURST_LEN         = 16,
    parameter int MAX_OUTSTANDING   = 4,
    parameter int SPACE_WIDTH       = 10
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         en,
    input  logic                         start_fetch,
    input  logic [TRANS_COUNT_WIDTH-1:0] trans_count,
    input  logic [SPACE_WIDTH-1:0]       fifo_space,
    input  logic                         error_clr,
    output logic                         axi_arvalid,
    input  logic                         axi_arready,
    input  logic                         axi_rvalid,
    output logic                         axi_rready,
    input  logic                         axi_rlast,
    input  logic [1:0]                   axi_rresp,
    output logic                         next_addr,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   error_flag,
    output logic                         len_err
);

    localparam int TCW = TRANS_COUNT_WIDTH;
    localparam int OW  = 4;
    localparam int BCW = $clog2(BURST_LEN + 1) + 1;
    localparam int CW  = ((SPACE_WIDTH > OW + BCW) ? SPACE_WIDTH : OW + BCW) + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TCW-1:0]   remaining_ar_q, remaining_ar_d;
    logic [TCW-1:0]   remaining_r_q, remaining_r_d;
    logic [OW-1:0]    outstanding_q, outstanding_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic             arvalid_q, arvalid_d;
    logic             done_q, done_d;
    logic [1:0]       error_q, error_d;
    logic             len_err_q, len_err_d;

    logic             ar_hs;
    logic             r_hs;
    logic             r_last_hs;
    logic             start_go;
    logic [OW-1:0]    out_post;

    // Space still owed to in-flight bursts plus one more burst must fit in the FIFO.
    function automatic logic issue_ok(input logic [TCW-1:0]         rem,
                                      input logic [OW-1:0]          outs,
                                      input logic [BCW-1:0]         beats,
                                      input logic [SPACE_WIDTH-1:0] space);
        logic [CW-1:0] held;
        logic [CW-1:0] used;
        logic [CW-1:0] need;
        held = CW'(outs) * CW'(BURST_LEN);
        used = (CW'(beats) > held) ? held : CW'(beats);
        need = held - used + CW'(BURST_LEN);
        return (rem != '0) && (outs < OW'(MAX_OUTSTANDING)) && (CW'(space) >= need);
    endfunction

    assign busy        = (state_q != ST_IDLE);
    assign axi_rready  = busy && en;
    assign axi_arvalid = arvalid_q;
    assign ar_hs       = arvalid_q && axi_arready;
    assign next_addr   = ar_hs;
    assign r_hs        = axi_rvalid && axi_rready;
    assign r_last_hs   = r_hs && axi_rlast;
    assign start_go    = (state_q == ST_IDLE) && en && start_fetch && (trans_count != '0);
    assign out_post    = outstanding_q + OW'(ar_hs);
    assign done        = done_q;
    assign error_flag  = error_q;
    assign len_err     = len_err_q;

    always_comb begin
        remaining_ar_d = remaining_ar_q;
        if (start_go)
            remaining_ar_d = trans_count;
        else if (ar_hs && remaining_ar_q != '0)
            remaining_ar_d = remaining_ar_q - TCW'(1);
    end

    always_comb begin
        remaining_r_d = remaining_r_q;
        if (start_go)
            remaining_r_d = trans_count;
        else if (r_last_hs && remaining_r_q != '0)
            remaining_r_d = remaining_r_q - TCW'(1);
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({ar_hs, r_last_hs && (outstanding_q != '0)})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // A burst that overruns BURST_LEN keeps counting (saturating) until its rlast.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        if (r_hs) begin
            if (axi_rlast) begin
                beat_cnt_d = '0;
                if (beat_cnt_q != BCW'(BURST_LEN - 1))
                    len_err_d = 1'b1;
            end else begin
                if (beat_cnt_q != '1)
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                if (beat_cnt_q == BCW'(BURST_LEN - 1))
                    len_err_d = 1'b1;
            end
        end
        if (en && error_clr)
            len_err_d = 1'b0;
    end

    always_comb begin
        error_d = error_q;
        if (en && error_clr)
            error_d = 2'b00;
        else if (r_hs && (axi_rresp > error_q))
            error_d = axi_rresp;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            remaining_ar_q <= '0;
            remaining_r_q  <= '0;
            outstanding_q  <= '0;
            beat_cnt_q     <= '0;
            error_q        <= 2'b00;
            len_err_q      <= 1'b0;
            arvalid_q      <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            remaining_ar_q <= remaining_ar_d;
            remaining_r_q  <= remaining_r_d;
            outstanding_q  <= outstanding_d;
            beat_cnt_q     <= beat_cnt_d;
            error_q        <= error_d;
            len_err_q      <= len_err_d;
            arvalid_q      <= arvalid_d;
            done_q         <= done_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state; counters reflect any handshake taken this cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_go)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (en && remaining_ar_d == '0)
                    state_d = (remaining_r_d == '0) ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (en && remaining_r_d == '0)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; a handshaking AR re-evaluates credit so bursts can issue back to back
    always_comb begin
        arvalid_d = arvalid_q && !ar_hs;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && start_fetch && trans_count == '0)
                    done_d = 1'b1;
                if (start_go)
                    arvalid_d = issue_ok(trans_count, outstanding_q, beat_cnt_q, fifo_space);
            end
            ST_RUN: begin
                if (en && (!arvalid_q || ar_hs))
                    arvalid_d = issue_ok(remaining_ar_d, out_post, beat_cnt_q, fifo_space);
                if (en && state_d == ST_IDLE)
                    done_d = 1'b1;
            end
            ST_DRAIN: begin
                if (en && state_d == ST_IDLE)
                    done_d = 1'b1;
            end
            default: begin
                arvalid_d = 1'b0;
                done_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dc_fu_dma_burst_manager.sv
// Directed bench for dc_fu_dma_burst_manager with a small in-order AXI read slave.
`timescale 1ns/1ps
module tb_dc_fu_dma_burst_manager;

    logic        clk;
    logic        nrst;
    logic        en;
    logic        start_fetch;
    logic [11:0] trans_count;
    logic [9:0]  fifo_space;
    logic        error_clr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic        axi_rvalid;
    logic        axi_rready;
    logic        axi_rlast;
    logic [1:0]  axi_rresp;
    logic        next_addr;
    logic        busy;
    logic        done;
    logic [1:0]  error_flag;
    logic        len_err;

    dc_fu_dma_burst_manager #(
        .TRANS_COUNT_WIDTH(12),
        .BURST_LEN(16),
        .MAX_OUTSTANDING(4),
        .SPACE_WIDTH(10)
    ) dut (
        .clk(clk), .nrst(nrst), .en(en), .start_fetch(start_fetch),
        .trans_count(trans_count), .fifo_space(fifo_space), .error_clr(error_clr),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready), .axi_rlast(axi_rlast), .axi_rresp(axi_rresp),
        .next_addr(next_addr), .busy(busy), .done(done), .error_flag(error_flag),
        .len_err(len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int cyc_no = 0;
    int pend = 0;
    int beat = 0;
    int burst_idx = 0;
    bit r_en = 0;
    bit short_first = 0;
    bit resp_mode = 0;
    int na_cnt = 0;
    int tot_beats = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_beat_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_slave();
        axi_rvalid = r_en && (pend > 0);
        axi_rlast  = ((beat + 1) == ((short_first && burst_idx == 0) ? 8 : 16));
        axi_rresp  = (resp_mode && beat == 1) ? 2'd2 : 2'd0;
    endtask

    task automatic cyc();
        bit ah, rh, rl;
        #1;
        ah = axi_arvalid && axi_arready;
        rh = axi_rvalid && axi_rready;
        rl = axi_rlast;
        if (next_addr) na_cnt++;
        @(posedge clk);
        cyc_no++;
        #1;
        if (ah) pend++;
        if (rh) begin
            tot_beats++;
            last_beat_cyc = cyc_no - 1;
            beat++;
            if (rl) begin
                pend--;
                beat = 0;
                burst_idx++;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_no;
        end
        drive_slave();
    endtask

    task automatic clr_stats();
        na_cnt = 0; tot_beats = 0; done_cnt = 0; burst_idx = 0; beat = 0;
        short_first = 0; resp_mode = 0;
    endtask

    task automatic start(input int tc);
        trans_count = 12'(tc);
        start_fetch = 1'b1;
        cyc();
        start_fetch = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input int bound);
        for (int i = 0; i < bound && done_cnt == 0; i++) cyc();
        chk(tag, done_cnt, 1);
    endtask

    initial begin
        nrst = 0; en = 0; start_fetch = 0; trans_count = 0; fifo_space = 0;
        error_clr = 0; axi_arready = 0; axi_rvalid = 0; axi_rlast = 0; axi_rresp = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_rready", axi_rready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error_flag, 0);
        chk("rst_lenerr", len_err, 0);
        nrst = 1;
        en = 1; fifo_space = 10'd1023; axi_arready = 1;
        cyc();

        // zero-length request
        clr_stats();
        start(0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_arvalid", axi_arvalid, 0);
        cyc();
        chk("zero_done_pulse", done, 0);

        // three bursts, R streaming continuously
        clr_stats();
        r_en = 1;
        start(3);
        chk("t1_na1", next_addr, 1);
        cyc();
        chk("t1_na2", next_addr, 1);
        cyc();
        chk("t1_na3", next_addr, 1);
        cyc();
        chk("t1_arv_low", axi_arvalid, 0);
        run_to_done("t1_done", 200);
        chk("t1_beats", tot_beats, 48);
        chk("t1_done_lat", done_cyc, last_beat_cyc + 1);
        chk("t1_na_cnt", na_cnt, 3);
        chk("t1_err", error_flag, 0);
        cyc();
        chk("t1_done_pulse", done, 0);
        chk("t1_busy", busy, 0);

        // outstanding limit with R stalled
        clr_stats();
        r_en = 0;
        start(8);
        repeat (10) cyc();
        chk("t2_na4", na_cnt, 4);
        chk("t2_arv_low", axi_arvalid, 0);
        r_en = 1;
        drive_slave();
        for (int i = 0; i < 40 && na_cnt < 5; i++) cyc();
        chk("t2_na5", na_cnt, 5);
        chk("t2_one_burst", burst_idx, 1);
        run_to_done("t2_done", 400);
        chk("t2_beats", tot_beats, 128);
        chk("t2_na8", na_cnt, 8);

        // FIFO credit gating
        clr_stats();
        r_en = 0;
        fifo_space = 10'd20;
        drive_slave();
        start(2);
        repeat (8) cyc();
        chk("t3_na1", na_cnt, 1);
        fifo_space = 10'd32;
        repeat (4) cyc();
        chk("t3_na2", na_cnt, 2);
        fifo_space = 10'd1023;
        r_en = 1;
        drive_slave();
        run_to_done("t3_done", 200);
        chk("t3_beats", tot_beats, 32);

        // worst RRESP capture
        clr_stats();
        resp_mode = 1;
        start(1);
        run_to_done("t4_done", 100);
        chk("t4_err", error_flag, 2);
        cyc();
        chk("t4_err_hold", error_flag, 2);
        chk("t4_lenerr", len_err, 0);
        error_clr = 1;
        cyc();
        error_clr = 0;
        chk("t4_clr", error_flag, 0);

        // early rlast on beat 8 of the first burst
        clr_stats();
        short_first = 1;
        drive_slave();
        start(2);
        run_to_done("t5_done", 200);
        chk("t5_lenerr", len_err, 1);
        chk("t5_beats", tot_beats, 24);
        chk("t5_err", error_flag, 0);
        error_clr = 1;
        cyc();
        error_clr = 0;
        chk("t5_clr", len_err, 0);

        // en=0 with a pending AR
        clr_stats();
        r_en = 0;
        axi_arready = 0;
        drive_slave();
        start(5);
        chk("t6_arv", axi_arvalid, 1);
        en = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) axi_arready = 1;
            #1;
            chk("t6_rready", axi_rready, 0);
            if (i <= 2) chk("t6_arv_hold", axi_arvalid, 1);
            if (i == 2) chk("t6_next_addr", next_addr, 1);
            cyc();
            if (i == 2) axi_arready = 0;
        end
        chk("t6_na_frozen", na_cnt, 1);
        chk("t6_busy", busy, 1);
        en = 1;
        axi_arready = 1;
        repeat (10) cyc();
        chk("t6_na_limit", na_cnt, 4);
        r_en = 1;
        drive_slave();
        run_to_done("t6_done", 300);
        chk("t6_na_total", na_cnt, 5);
        chk("t6_beats", tot_beats, 80);

        // asynchronous reset mid-transfer
        clr_stats();
        r_en = 0;
        axi_arready = 0;
        drive_slave();
        start(2);
        chk("t7_arv", axi_arvalid, 1);
        #2;
        nrst = 0;
        #1;
        chk("t7_rst_arv", axi_arvalid, 0);
        chk("t7_rst_busy", busy, 0);
        pend = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dc_fu_dma_burst_manager.md
Name: dc_fu_dma_burst_manager

Overview:
AXI4 read-channel handshake manager for the fetch-unit DMA, supporting up to MAX_OUTSTANDING bursts in flight. Issues AR requests for a programmed number of fixed-length bursts and gates each issue on downstream buffer credit. Counts R beats, checks burst length against rlast, and records the worst RRESP. It sits between the DMA address generator (driven by next_addr) and the AXI read port.

Parameters:
TRANS_COUNT_WIDTH, 12, width of the burst-count request
BURST_LEN, 16, beats per burst (power of two, 1..256)
MAX_OUTSTANDING, 4, maximum AR-accepted bursts awaiting final rlast (1..15)
SPACE_WIDTH, 10, width of the fifo_space input

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
en  in  1  global enable; 0 freezes the block
start_fetch  in  1  start pulse; sampled only in IDLE
trans_count  in  TRANS_COUNT_WIDTH  number of bursts; latched on start
fifo_space  in  SPACE_WIDTH  free beat slots in the downstream FIFO
error_clr  in  1  clears sticky error_flag and len_err
axi_arvalid  out  1  AR valid
axi_arready  in  1  AR ready
axi_rvalid  in  1  R valid
axi_rready  out  1  R ready
axi_rlast  in  1  R last
axi_rresp  in  2  R response
next_addr  out  1  one-cycle pulse on each AR handshake; address generator advances
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer completion
error_flag  out  2  sticky maximum RRESP seen
len_err  out  1  sticky: rlast arrived on the wrong beat

Behaviour:
- Reset values: axi_arvalid=0, axi_rready=0, next_addr=0, busy=0, done=0, error_flag=0, len_err=0, all counters 0, FSM=IDLE.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start_fetch && en && trans_count!=0. Latch trans_count into remaining_ar and remaining_r.
  - IDLE with start_fetch && en && trans_count==0: done pulses the next cycle, FSM stays in IDLE, no AR issued.
  - RUN -> DRAIN when the last AR handshakes (remaining_ar reaches 0).
  - DRAIN -> IDLE when the final burst's rlast beat is accepted (remaining_r reaches 0). done pulses in the cycle after that beat.
- start_fetch outside IDLE is ignored.
- busy = (FSM != IDLE).
- Credit: reserved = outstanding*BURST_LEN - beats_received_in_current_bursts.
- Issue condition (evaluated in RUN with arvalid low, registered): remaining_ar!=0 && outstanding<MAX_OUTSTANDING && fifo_space >= reserved+BURST_LEN, compared at full width with no truncation.
  - When the condition holds, axi_arvalid rises the next cycle.
  - arvalid stays high until arready. It is never withdrawn, including when en=0.
- Latency:
  - start_fetch in cycle N -> earliest arvalid in N+1.
  - AR handshake in cycle M with the issue condition still true -> arvalid may stay high in M+1 (back-to-back issue).
- next_addr = axi_arvalid && axi_arready. It is combinational and pulses in the handshake cycle.
- outstanding counter:
  - +1 on AR handshake, -1 on an accepted beat with rlast.
  - Both in the same cycle: unchanged.
  - It can never exceed MAX_OUTSTANDING.
- axi_rready = busy && en. All beats have reserved space, so rready is independent of fifo_space.
- Beat counter:
  - Counts accepted beats (rvalid && rready) within the current burst and resets on rlast.
  - rlast on beat != BURST_LEN, or no rlast on beat BURST_LEN: set len_err. The burst is then treated as complete at the rlast.
- error_flag: on each accepted beat, error_flag <= max(error_flag, rresp). error_clr has priority over an update in the same cycle.
- en=0:
  - All FSM, counter and sticky-flag updates freeze, and no new AR is issued.
  - A pending arvalid stays asserted. Its handshake is still counted and next_addr still pulses.
  - rready is 0.
- Asynchronous reset mid-transfer: immediate return to reset values. Outstanding AXI transactions are abandoned; system-level reset of the interconnect is required.

Test Plan:
- trans_count=3, fifo_space=1023, arready=1, rvalid=1 continuous -> 3 back-to-back next_addr pulses in cycles N+1..N+3, 48 beats accepted, done one cycle after the 48th beat, error_flag=0.
- trans_count=8, MAX_OUTSTANDING=4, R channel stalled -> exactly 4 AR handshakes, arvalid stays low. After one rlast burst completes, the 5th AR issues.
- fifo_space=20, BURST_LEN=16, trans_count=2, R stalled -> only 1 AR issued. fifo_space raised to 32 -> 2nd AR issues.
- rresp pattern OKAY, SLVERR, OKAY on beats 1..3 -> error_flag=2 and stays 2 after completion. error_clr -> 0.
- rlast asserted on beat 8 of 16 -> len_err=1, burst counted complete, transfer still finishes with done.
- arvalid high with arready=0, then en=0 for 5 cycles -> arvalid stays 1 and rready=0. arready in that window -> next_addr pulses and outstanding increments.
